// File: rtl/conv_block_buffer.sv
// conv_block_buffer
//   Single-block buffer feeding the tail-biting convolutional encoder.
//   Collects one framed code block (small or large) from a byte stream,
//   captures the last six bits of the block as the encoder start state,
//   and presents the block through a show-ahead meta/data read interface.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   in_data        block byte, bit 0 earliest in time
//   in_valid       in_data valid; transfer on in_valid & in_ready
//   in_sof         marks the first byte of a block
//   in_size        block size, sampled with in_sof (0 small, 1 large)
//   in_ready       buffer accepts a byte this cycle
//   blk_ready      whole block buffered and meta not yet read
//   blk_empty      no unread data bytes remain
//   blk_meta       {tail[5:0], 1'b0, size}, show-ahead
//   blk_data       current head byte, show-ahead
//   blk_meta_rdreq pop the single meta entry
//   blk_data_rdreq pop the head data byte
//   err            one-cycle pulse after a framing error
module conv_block_buffer #(
    parameter int SMALL_BYTES = 132,
    parameter int LARGE_BYTES = 768,
    parameter int ADDR_W      = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic       in_size,
    output logic       in_ready,
    output logic       blk_ready,
    output logic       blk_empty,
    output logic [7:0] blk_meta,
    output logic [7:0] blk_data,
    input  logic       blk_meta_rdreq,
    input  logic       blk_data_rdreq,
    output logic       err
);

    localparam logic [ADDR_W-1:0] SMALL_LAST = ADDR_W'(SMALL_BYTES - 1);
    localparam logic [ADDR_W-1:0] LARGE_LAST = ADDR_W'(LARGE_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        READY,
        DRAIN
    } state_t;

    state_t state;
    state_t next_state;

    logic [7:0]        mem [2**ADDR_W];
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] last_idx;
    logic              size_q;
    logic [7:0]        meta_q;
    logic              empty_q;
    logic              ready_q;
    logic              err_q;

    // Handshake strobes
    logic              in_fire;
    logic              fill_last;
    logic              data_pop;
    logic              last_pop;
    logic              meta_pop;

    // Output-process results
    logic              in_ready_d;
    logic              err_d;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              blk_ready_c;

    assign last_idx  = size_q ? LARGE_LAST : SMALL_LAST;

    // ready_q is only high in IDLE/FILL, so in_fire implies one of those states.
    assign in_fire   = in_valid && ready_q;
    assign fill_last = (state == FILL) && !in_sof && (count == last_idx);

    // empty_q is only low in READY/DRAIN, so no extra state qualification is needed.
    assign data_pop  = blk_data_rdreq && !empty_q;
    assign last_pop  = data_pop && (rd_ptr == last_idx);
    assign meta_pop  = blk_meta_rdreq && (state == READY);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_fire && in_sof) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (in_fire && fill_last) begin
                    next_state = READY;
                end
            end
            READY: begin
                // Meta read after (or together with) the final pop ends the block;
                // otherwise the remaining bytes drain without meta.
                if (meta_pop) begin
                    if (empty_q || last_pop) begin
                        next_state = IDLE;
                    end else begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_d  = (next_state == IDLE) || (next_state == FILL);
        blk_ready_c = (state == READY);
        err_d       = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        if (in_fire) begin
            if (state == IDLE) begin
                err_d = !in_sof;
                wr_en = in_sof;
            end else begin
                // Restart on sof overwrites from address 0.
                err_d = in_sof;
                wr_en = 1'b1;
            end
            wr_addr = in_sof ? '0 : count;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            rd_ptr  <= '0;
            size_q  <= 1'b0;
            meta_q  <= '0;
            empty_q <= 1'b1;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= in_ready_d;
            err_q   <= err_d;

            if (in_fire) begin
                if (in_sof) begin
                    size_q <= in_size;
                    count  <= ADDR_W'(1);
                end else if (state == FILL) begin
                    if (fill_last) begin
                        count   <= '0;
                        rd_ptr  <= '0;
                        empty_q <= 1'b0;
                        meta_q  <= {in_data[7:2], 1'b0, size_q};
                    end else begin
                        count <= count + ADDR_W'(1);
                    end
                end
            end

            if (data_pop) begin
                if (last_pop) begin
                    rd_ptr  <= '0;
                    empty_q <= 1'b1;
                end else begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
            end

            // Meta is a single-entry queue: reading it empties it.
            if (meta_pop) begin
                meta_q <= '0;
            end
        end
    end

    // Buffer storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
    end

    assign in_ready  = ready_q;
    assign blk_ready = blk_ready_c;
    assign blk_empty = empty_q;
    assign blk_meta  = meta_q;
    assign blk_data  = empty_q ? 8'h00 : mem[rd_ptr];
    assign err       = err_q;

endmodule

// File: tb/tb_conv_block_buffer.sv
module tb_conv_block_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_sof;
    logic       in_size;
    logic       in_ready;
    logic       blk_ready;
    logic       blk_empty;
    logic [7:0] blk_meta;
    logic [7:0] blk_data;
    logic       blk_meta_rdreq;
    logic       blk_data_rdreq;
    logic       err;

    int tests = 0;
    int fails = 0;
    int err_events = 0;

    logic [7:0] exp_data[$];
    logic [7:0] exp_meta[$];

    conv_block_buffer #(
        .SMALL_BYTES(132),
        .LARGE_BYTES(768),
        .ADDR_W(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_sof(in_sof),
        .in_size(in_size),
        .in_ready(in_ready),
        .blk_ready(blk_ready),
        .blk_empty(blk_empty),
        .blk_meta(blk_meta),
        .blk_data(blk_data),
        .blk_meta_rdreq(blk_meta_rdreq),
        .blk_data_rdreq(blk_data_rdreq),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Counts err pulses so sections can check how many occurred.
    always @(negedge clk) begin
        if (reset && err) err_events++;
    end

    // Scoreboard monitor: compares head byte / meta whenever a pop is taken.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset) begin
                if (blk_data_rdreq && !blk_empty) begin
                    if (exp_data.size() == 0) check("data_underflow", 1, 0);
                    else check("blk_data", blk_data, exp_data.pop_front());
                end
                if (blk_meta_rdreq && blk_ready) begin
                    if (exp_meta.size() == 0) check("meta_underflow", 1, 0);
                    else check("blk_meta", blk_meta, exp_meta.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sof, input logic sz);
        int unsigned waited = 0;
        in_data  = d;
        in_sof   = sof;
        in_size  = sz;
        in_valid = 1'b1;
        while (!in_ready && waited < 20000) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Sends bytes seed + i*step, i = first..n-1; i = 0 carries sof.
    task automatic send_range(input int first, input int n, input logic sz,
                              input logic [7:0] seed, input logic [7:0] step);
        logic [7:0] b;
        for (int i = first; i < n; i++) begin
            b = seed + 8'(i) * step;
            exp_data.push_back(b);
            if (i == n - 1 && n >= 132) exp_meta.push_back({b[7:2], 1'b0, sz});
            send_byte(b, (i == 0), sz);
        end
    endtask

    task automatic pop_data(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            blk_data_rdreq = 1'b1;
            tick();
            blk_data_rdreq = 1'b0;
            for (int g = 1; g < gap; g++) tick();
        end
    endtask

    task automatic pop_meta();
        blk_meta_rdreq = 1'b1;
        tick();
        blk_meta_rdreq = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_blk_ready"}, blk_ready, 0);
        check({tag, "_blk_empty"}, blk_empty, 1);
        check({tag, "_blk_meta"}, blk_meta, 8'h00);
        check({tag, "_blk_data"}, blk_data, 8'h00);
        check({tag, "_err"}, err, 0);
    endtask

    // Asserts reset mid-cycle, checks outputs immediately, then releases.
    task automatic mid_reset(input string tag);
        @(posedge clk);
        #3;
        reset = 1'b0;
        in_valid = 1'b0; in_sof = 1'b0;
        blk_data_rdreq = 1'b0; blk_meta_rdreq = 1'b0;
        #1;
        check_reset_outputs(tag);
        exp_data.delete();
        exp_meta.delete();
        tick();
        reset = 1'b1;
        check({tag, "_in_ready_rel"}, in_ready, 0);
        tick();
        check({tag, "_in_ready_up"}, in_ready, 1);
    endtask

    initial begin : stimulus
        int e0;
        reset = 1'b1;
        in_data = '0; in_valid = 1'b0; in_sof = 1'b0; in_size = 1'b0;
        blk_meta_rdreq = 1'b0; blk_data_rdreq = 1'b0;
        #2 reset = 1'b0;
        #6;
        check_reset_outputs("rst");
        tick();
        reset = 1'b1;
        check("rel_in_ready0", in_ready, 0);
        tick();
        check("rel_in_ready1", in_ready, 1);

        // Small block 0x00..0x83, encoder-style start
        send_range(0, 132, 1'b0, 8'h00, 8'h01);
        check("small_in_ready", in_ready, 0);
        check("small_blk_ready", blk_ready, 1);
        check("small_blk_empty", blk_empty, 0);
        check("small_meta", blk_meta, 8'h80);
        check("small_head", blk_data, 8'h00);
        blk_meta_rdreq = 1'b1;
        blk_data_rdreq = 1'b1;
        tick();
        blk_meta_rdreq = 1'b0;
        blk_data_rdreq = 1'b0;
        check("enc_blk_ready", blk_ready, 0);
        check("enc_head1", blk_data, 8'h01);
        pop_data(131, 1);
        check("small_empty", blk_empty, 1);
        check("small_data0", blk_data, 8'h00);
        check("small_idle_ready", in_ready, 1);
        pop_data(3, 1);
        check("extra_pop_empty", blk_empty, 1);
        check("extra_pop_data", blk_data, 8'h00);

        // Large block, last byte 0xFF; drain every 8th cycle before meta
        send_range(0, 768, 1'b1, 8'h00, 8'h01);
        check("large_meta", blk_meta, 8'hFD);
        check("large_blk_ready", blk_ready, 1);
        pop_data(768, 8);
        check("large_empty", blk_empty, 1);
        check("large_ready_held", blk_ready, 1);
        check("large_in_ready_held", in_ready, 0);
        pop_meta();
        check("large_in_ready", in_ready, 1);

        // Framing error: byte without sof in IDLE
        e0 = err_events;
        send_byte(8'hA5, 1'b0, 1'b0);
        check("idle_err_pulse", err, 1);
        tick();
        check("idle_err_clear", err, 0);
        check("idle_err_count", err_events - e0, 1);

        // Framing error: sof after 50 bytes restarts the block
        send_range(0, 50, 1'b0, 8'h40, 8'h03);
        e0 = err_events;
        exp_data.delete();
        send_range(0, 1, 1'b0, 8'h90, 8'h05);
        check("fill_err_pulse", err, 1);
        send_range(1, 131, 1'b0, 8'h90, 8'h05);
        check("restart_not_done", blk_ready, 0);
        check("restart_in_ready", in_ready, 1);
        send_range(131, 132, 1'b0, 8'h90, 8'h05);
        check("restart_done", blk_ready, 1);
        check("restart_err_count", err_events - e0, 1);
        // Meta first, then drain in DRAIN
        pop_meta();
        check("drain_blk_ready", blk_ready, 0);
        check("drain_head", blk_data, 8'h90);
        pop_data(132, 2);
        check("drain_in_ready", in_ready, 1);

        // Reset mid-FILL at byte 70
        send_range(0, 70, 1'b0, 8'h11, 8'h02);
        mid_reset("rfill");
        send_range(0, 132, 1'b0, 8'h07, 8'h0B);
        pop_meta();
        pop_data(132, 1);
        check("rfill_clean_empty", blk_empty, 1);

        // Reset mid-DRAIN at pop 10
        send_range(0, 132, 1'b0, 8'h20, 8'h07);
        pop_meta();
        pop_data(10, 1);
        mid_reset("rdrain");
        send_range(0, 132, 1'b1 ^ 1'b1, 8'h33, 8'h01);
        pop_data(132, 1);
        pop_meta();
        check("rdrain_clean_idle", in_ready, 1);

        // Back-pressure: next block's sof byte held during READY/DRAIN
        send_range(0, 132, 1'b0, 8'h10, 8'h03);
        e0 = err_events;
        fork
            begin
                exp_data.push_back(8'h55);
                send_byte(8'h55, 1'b1, 1'b0);
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    check("bp_in_ready_low", in_ready, 0);
                    tick();
                end
                pop_meta();
                pop_data(132, 2);
            end
        join
        check("bp_err_count", err_events - e0, 0);
        send_range(1, 132, 1'b0, 8'h55, 8'h01);
        check("bp_meta", blk_meta, 8'hD8);
        pop_data(132, 1);
        pop_meta();
        check("bp_in_ready", in_ready, 1);

        tick();
        tick();
        check("exp_data_left", exp_data.size(), 0);
        check("exp_meta_left", exp_meta.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
